cond_exec_ctrl: RTL

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

---
 rtl/cond_exec_ctrl_pkg.sv | 38 +++
 rtl/cond_exec_ctrl_cond_eval.sv | 46 ++++
 rtl/cond_exec_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cond_exec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cond_exec_ctrl_pkg
// Shared definitions for the conditional-execution controller:
//   - ARM 4-bit condition-code constants (EQ..AL, NV)
//   - FSM state encoding
//   - bit positions of N, Z, C, V inside a {N,Z,C,V} flags vector
// -----------------------------------------------------------------------------
package cond_exec_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EVAL       = 2'd1,
    ST_WAIT_FLAGS = 2'd2
  } state_t;

endpackage

// File: rtl/cond_exec_ctrl_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational ARM condition-code check.
// Ports:
//   cond  in  [3:0]  condition field of the instruction
//   nzcv  in  [3:0]  current flags, {N,Z,C,V}
//   pass  out        1 when the condition holds
// -----------------------------------------------------------------------------
module cond_eval
  import cond_exec_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[NZCV_N];
  assign w_z = nzcv[NZCV_Z];
  assign w_c = nzcv[NZCV_C];
  assign w_v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // NV: never executes
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// -----------------------------------------------------------------------------
// cond_exec_ctrl
// Accepts an instruction's condition field, evaluates it one cycle later
// against the architectural NZCV register, and pulses EXEC or SQUASH.
// Executed flag-setting instructions wait for the ALU flags before the next
// instruction is accepted; squashed instructions never touch NZCV.
//
// Optional feature (macro COND_EXEC_OVERLAP_EN):
//   when defined, the WAIT_FLAGS state accepts a new instruction on the same
//   edge the ALU flags arrive, and that instruction is evaluated against the
//   freshly loaded flags.
//
// Ports:
//   CLK              in   rising-edge clock
//   CLR_N            in   asynchronous active-low reset
//   IR_VALID         in   instruction offered
//   IR_READY         out  controller accepts the offered instruction
//   COND             in   [3:0] condition field
//   SET_FLAGS        in   instruction writes NZCV (S bit)
//   ALU_FLAGS_VALID  in   ALU_NZCV is valid this cycle
//   ALU_NZCV         in   [3:0] ALU result flags {N,Z,C,V}
//   EXEC             out  one-cycle pulse, condition passed
//   SQUASH           out  one-cycle pulse, condition failed
//   NZCV             out  [3:0] architectural flags
//   BUSY             out  FSM not in IDLE
//   SQUASH_CNT       out  [CNT_W-1:0] saturating squash counter
// -----------------------------------------------------------------------------
module cond_exec_ctrl
  import cond_exec_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             IR_VALID,
  output logic             IR_READY,
  input  logic [3:0]       COND,
  input  logic             SET_FLAGS,
  input  logic             ALU_FLAGS_VALID,
  input  logic [3:0]       ALU_NZCV,
  output logic             EXEC,
  output logic             SQUASH,
  output logic [3:0]       NZCV,
  output logic             BUSY,
  output logic [CNT_W-1:0] SQUASH_CNT
);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_cond;
  logic             r_set_flags;
  logic [3:0]       r_nzcv;
  logic [CNT_W-1:0] r_squash_cnt;

  logic             w_pass;
  logic             w_xfer;
  logic             w_flag_load;
  logic             w_in_eval;

  cond_eval u_cond_eval (
    .cond (r_cond),
    .nzcv (r_nzcv),
    .pass (w_pass)
  );

  assign w_xfer    = IR_VALID & IR_READY;
  assign w_in_eval = (r_state == ST_EVAL);

  // Pulses are decoded from the state so a reset removes them immediately.
  assign EXEC       = w_in_eval & w_pass;
  assign SQUASH     = w_in_eval & ~w_pass;
  assign BUSY       = (r_state != ST_IDLE);
  assign NZCV       = r_nzcv;
  assign SQUASH_CNT = r_squash_cnt;

  always_comb begin
    w_next_state = r_state;
    IR_READY     = 1'b0;
    w_flag_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        IR_READY = 1'b1;
        if (IR_VALID) w_next_state = ST_EVAL;
      end
      ST_EVAL: begin
        // Only an executed S-instruction has flags to wait for.
        if (w_pass && r_set_flags) w_next_state = ST_WAIT_FLAGS;
        else                       w_next_state = ST_IDLE;
      end
      ST_WAIT_FLAGS: begin
`ifdef COND_EXEC_OVERLAP_EN
        IR_READY = ALU_FLAGS_VALID;
`endif
        if (ALU_FLAGS_VALID) begin
          w_flag_load  = 1'b1;
          w_next_state = w_xfer ? ST_EVAL : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state      <= ST_IDLE;
      r_cond       <= COND_NV;
      r_set_flags  <= 1'b0;
      r_nzcv       <= 4'b0000;
      r_squash_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_xfer) begin
        r_cond      <= COND;
        r_set_flags <= SET_FLAGS;
      end
      if (w_flag_load) r_nzcv <= ALU_NZCV;
      if (SQUASH && !(&r_squash_cnt))
        r_squash_cnt <= r_squash_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
